sargantana_icache_replace_unit: RTL and testbench
=================================================

SARGANTANA_ICACHE_REPLACE_UNIT -- requirements
Module: sargantana_icache_replace_unit

Interface
REQ-001 The parameter N_SETS SHALL default to 64 and give the number of cache sets; SET_W = clog2(N_SETS), with a default of 6.
REQ-002 The way count SHALL be fixed at ICACHE_N_WAY = 4, so ICACHE_N_WAY_CLOG2 = 2.
REQ-003 The block SHALL have one clock and one reset: clk_i (in, 1, rising-edge clock) and rstn_i (in, 1, asynchronous active-low reset).
REQ-004 flush_i (in, 1) SHALL clear all replacement state.
REQ-005 hit_valid_i (in, 1) SHALL qualify a lookup hit.
REQ-006 hit_set_i (in, SET_W) SHALL give the set index of the hit.
REQ-007 hit_way_i (in, 4) SHALL give the hit way as a one-hot vector.
REQ-008 fill_req_i (in, 1) SHALL request a victim selection for a refill.
REQ-009 fill_set_i (in, SET_W) SHALL give the set index of the refill.
REQ-010 way_valid_i (in, 4) SHALL give the per-way valid bits of fill_set_i, sampled with fill_req_i.
REQ-011 victim_valid_o (out, 1) SHALL be a one-cycle pulse that qualifies the victim outputs.
REQ-012 victim_way_o (out, 2) SHALL give the selected way index.
REQ-013 victim_oh_o (out, 4) SHALL give the selected way as a one-hot way write enable.
REQ-014 victim_inval_o (out, 1) SHALL be 1 when the victim was an invalid way and 0 when it was chosen by PLRU.

Function
REQ-015 The block SHALL hold 3 tree-PLRU bits {b0,b1,b2} per set, N_SETS x 3 flops in total.
REQ-016 PLRU decode: b0=0 SHALL pick the {0,1} pair and b0=1 the {2,3} pair; b1=0 SHALL pick way0 and b1=1 way1; b2=0 SHALL pick way2 and b2=1 way3.
REQ-017 A touch of a way SHALL point the tree away from that way:
- way0 sets b0=1, b1=1
- way1 sets b0=1, b1=0
- way2 sets b0=0, b2=1
- way3 sets b0=0, b2=0
- all other bits are unchanged.
REQ-018 A hit SHALL touch one way, and the updated bits SHALL be visible from the next cycle.
- Touched way: lowest set bit of hit_way_i when hit_valid_i=1.
- hit_way_i = 0: no update.
REQ-019 A fill request SHALL select its victim from the current set state as follows:
- If any bit of way_valid_i is 0, the victim SHALL be the lowest-index invalid way and victim_inval_o SHALL be 1.
- If all ways are valid, the victim SHALL be the PLRU-decoded way and victim_inval_o SHALL be 0.
REQ-020 Latency SHALL be one cycle: victim_valid_o, victim_way_o, victim_oh_o and victim_inval_o are registered and asserted in the cycle after fill_req_i.
REQ-021 victim_valid_o SHALL be high for exactly one cycle per accepted request, with no backpressure; the block accepts one request per cycle.
REQ-022 Outside victim_valid_o, victim_way_o, victim_oh_o and victim_inval_o SHALL hold their last values.
REQ-023 The victim way SHALL be touched in the same cycle as it is selected, so a back-to-back fill to the same set sees the updated state.
REQ-024 When a hit and a fill arrive in the same cycle on the same set:
- The victim SHALL be computed from the state after the hit update (hit forwarded).
- The final stored state SHALL be the hit update followed by the victim touch.
REQ-025 When a hit and a fill arrive in the same cycle on different sets, both updates SHALL apply independently.
REQ-026 flush_i SHALL clear all PLRU bits to 0 at the next edge, with the following priority:
- A fill_req_i in the same cycle SHALL be dropped, and victim_valid_o SHALL be 0 next cycle.
- A hit in the same cycle SHALL be ignored.
REQ-027 Set indices SHALL be used modulo N_SETS, so no out-of-range access is possible.

Reset
REQ-028 While rstn_i=0, asynchronously:
- all PLRU bits = 0
- victim_valid_o = 0
- victim_way_o = 2'b00
- victim_oh_o = 4'b0000
- victim_inval_o = 0
REQ-029 A reset asserted mid-request SHALL discard the request, and no victim_valid_o pulse SHALL follow deassertion.
REQ-030 After reset, the first full-valid fill to any set SHALL select way0.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- (a) After reset, fill set 5 with way_valid=1111 -> next cycle valid=1, way=0, oh=0001, inval=0. A second fill to set 5 -> way=2, oh=0100.
- (b) Fill set 3 with way_valid=1011 -> way=2, oh=0100, inval=1. Then way_valid=0000 -> way=0, inval=1.
- (c) Hits to set 7 on ways 0, 2, 1 in successive cycles, then a full-valid fill to set 7 -> way=3.
- (d) In one cycle, hit set 9 way0 plus full-valid fill set 9 -> victim=way2 (forwarded). The following fill to set 9 -> way1.
- (e) Touch set 1 to non-zero state, then flush_i=1 together with fill_req_i -> no victim_valid. The next full fill to set 1 -> way0.
- (f) Assert rstn_i low in the cycle after fill_req_i -> victim_valid_o=0 immediately and remains 0 after release.

Source files
------------

// File: rtl/sargantana_icache_replace_unit_if.sv
// Lookup-hit / refill-victim signal bundle for the I-cache replacement unit.
// The slave side is the replacement unit; the master side is the cache controller.
interface sargantana_icache_replace_unit_if #(
    parameter int N_SETS = 64,
    parameter int SET_W  = $clog2(N_SETS)
);
    logic             flush_i;
    logic             hit_valid_i;
    logic [SET_W-1:0] hit_set_i;
    logic [3:0]       hit_way_i;
    logic             fill_req_i;
    logic [SET_W-1:0] fill_set_i;
    logic [3:0]       way_valid_i;
    logic             victim_valid_o;
    logic [1:0]       victim_way_o;
    logic [3:0]       victim_oh_o;
    logic             victim_inval_o;

    modport slave (
        input  flush_i, hit_valid_i, hit_set_i, hit_way_i,
        input  fill_req_i, fill_set_i, way_valid_i,
        output victim_valid_o, victim_way_o, victim_oh_o, victim_inval_o
    );

    modport master (
        output flush_i, hit_valid_i, hit_set_i, hit_way_i,
        output fill_req_i, fill_set_i, way_valid_i,
        input  victim_valid_o, victim_way_o, victim_oh_o, victim_inval_o
    );
endinterface

// File: rtl/sargantana_icache_replace_unit.sv
// 4-way tree-PLRU replacement unit: tracks hits per set and picks refill victims,
// preferring invalid ways, with a registered one-cycle victim result.
module sargantana_icache_replace_unit #(
    parameter int N_SETS = 64,
    parameter int SET_W  = $clog2(N_SETS)
) (
    input  logic clk_i,
    input  logic rstn_i,
    sargantana_icache_replace_unit_if.slave bus
);
    localparam int ICACHE_N_WAY       = 4;
    localparam int ICACHE_N_WAY_CLOG2 = 2;

    typedef logic [ICACHE_N_WAY_CLOG2-1:0] way_idx_t;

    // Tree bits per set: [0]=b0 (pair select), [1]=b1 (way0/1), [2]=b2 (way2/3)
    logic [2:0] plru_q [N_SETS];
    logic [2:0] plru_d [N_SETS];

    logic [SET_W-1:0]        hit_set;
    logic [SET_W-1:0]        fill_set;
    logic                    fill_go;
    way_idx_t                vic_way;
    logic                    vic_inval;
    logic [2:0]              fill_cur;

    logic                    victim_valid_q;
    way_idx_t                victim_way_q;
    logic [ICACHE_N_WAY-1:0] victim_oh_q;
    logic                    victim_inval_q;

    assign hit_set  = SET_W'(int'(bus.hit_set_i) % N_SETS);
    assign fill_set = SET_W'(int'(bus.fill_set_i) % N_SETS);

    function automatic way_idx_t lowest_idx(input logic [ICACHE_N_WAY-1:0] v);
        way_idx_t idx;
        idx = 2'd0;
        if (v[0])      idx = 2'd0;
        else if (v[1]) idx = 2'd1;
        else if (v[2]) idx = 2'd2;
        else if (v[3]) idx = 2'd3;
        return idx;
    endfunction

    function automatic way_idx_t plru_decode(input logic [2:0] b);
        way_idx_t idx;
        if (!b[0]) idx = b[1] ? 2'd1 : 2'd0;
        else       idx = b[2] ? 2'd3 : 2'd2;
        return idx;
    endfunction

    // Point the tree away from the touched way; untouched bits are kept.
    function automatic logic [2:0] plru_touch(input logic [2:0] b, input way_idx_t w);
        logic [2:0] r;
        r = b;
        case (w)
            2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
            2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
            2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
            default: begin r[0] = 1'b0; r[2] = 1'b0; end
        endcase
        return r;
    endfunction

    always_comb begin
        plru_d    = plru_q;
        fill_go   = 1'b0;
        vic_way   = 2'd0;
        vic_inval = 1'b0;
        fill_cur  = plru_q[fill_set];
        if (bus.flush_i) begin
            for (int s = 0; s < N_SETS; s++) plru_d[s] = 3'b000;
        end else begin
            if (bus.hit_valid_i && (|bus.hit_way_i))
                plru_d[hit_set] = plru_touch(plru_d[hit_set], lowest_idx(bus.hit_way_i));
            // Reading plru_d here forwards a same-cycle hit on the same set.
            if (bus.fill_req_i) begin
                fill_go  = 1'b1;
                fill_cur = plru_d[fill_set];
                if (&bus.way_valid_i) begin
                    vic_way   = plru_decode(fill_cur);
                    vic_inval = 1'b0;
                end else begin
                    vic_way   = lowest_idx(~bus.way_valid_i);
                    vic_inval = 1'b1;
                end
                plru_d[fill_set] = plru_touch(fill_cur, vic_way);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < N_SETS; s++) plru_q[s] <= 3'b000;
            victim_valid_q <= 1'b0;
            victim_way_q   <= 2'd0;
            victim_oh_q    <= 4'b0000;
            victim_inval_q <= 1'b0;
        end else begin
            plru_q         <= plru_d;
            victim_valid_q <= fill_go;
            if (fill_go) begin
                victim_way_q   <= vic_way;
                victim_oh_q    <= 4'b0001 << vic_way;
                victim_inval_q <= vic_inval;
            end
        end
    end

    assign bus.victim_valid_o = victim_valid_q;
    assign bus.victim_way_o   = victim_way_q;
    assign bus.victim_oh_o    = victim_oh_q;
    assign bus.victim_inval_o = victim_inval_q;
endmodule

// File: tb/tb_sargantana_icache_replace_unit.sv
// Directed bench for the I-cache PLRU replacement unit: a table of per-cycle
// vectors with hand-computed victims, plus reset-during-request sequences.
module tb_sargantana_icache_replace_unit;
    logic clk_i;
    logic rstn_i;
    int   checks;
    int   errors;

    sargantana_icache_replace_unit_if #(.N_SETS(64)) bus ();

    sargantana_icache_replace_unit #(.N_SETS(64)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       flush;
        logic       hv;
        logic [5:0] hs;
        logic [3:0] hw;
        logic       fr;
        logic [5:0] fs;
        logic [3:0] wv;
        logic       ev;
        logic [1:0] ew;
        logic [3:0] eoh;
        logic       ei;
    } vec_t;

    localparam int N_VEC = 26;
    vec_t vecs [N_VEC];

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic check_out(input int idx, input logic ev, input logic [1:0] ew,
                             input logic [3:0] eoh, input logic ei);
        check("valid", idx, {3'b000, bus.victim_valid_o}, {3'b000, ev});
        check("way",   idx, {2'b00, bus.victim_way_o},    {2'b00, ew});
        check("oh",    idx, bus.victim_oh_o,              eoh);
        check("inval", idx, {3'b000, bus.victim_inval_o}, {3'b000, ei});
    endtask

    task automatic idle_inputs();
        bus.flush_i     = 1'b0;
        bus.hit_valid_i = 1'b0;
        bus.hit_set_i   = '0;
        bus.hit_way_i   = 4'b0000;
        bus.fill_req_i  = 1'b0;
        bus.fill_set_i  = '0;
        bus.way_valid_i = 4'b0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //          flush hv   hs     hw       fr   fs     wv        ev   ew     eoh      ei
        vecs[0]  = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd5,  4'b1111, 1'b1, 2'd0, 4'b0001, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd5,  4'b1111, 1'b1, 2'd2, 4'b0100, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd2, 4'b0100, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd3,  4'b1011, 1'b1, 2'd2, 4'b0100, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd3,  4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 6'd7,  4'b0001, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 6'd7,  4'b0100, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 6'd7,  4'b0010, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd7,  4'b1111, 1'b1, 2'd3, 4'b1000, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 6'd9,  4'b0001, 1'b1, 6'd9,  4'b1111, 1'b1, 2'd2, 4'b0100, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd9,  4'b1111, 1'b1, 2'd1, 4'b0010, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 6'd1,  4'b0001, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd1, 4'b0010, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd1,  4'b1111, 1'b0, 2'd1, 4'b0010, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd1,  4'b1111, 1'b1, 2'd0, 4'b0001, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd5,  4'b1111, 1'b1, 2'd0, 4'b0001, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 6'd20, 4'b0110, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd0, 4'b0001, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd20, 4'b1111, 1'b1, 2'd2, 4'b0100, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 6'd21, 4'b0000, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd2, 4'b0100, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd21, 4'b1111, 1'b1, 2'd0, 4'b0001, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 6'd30, 4'b0001, 1'b1, 6'd31, 4'b1111, 1'b1, 2'd0, 4'b0001, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd30, 4'b1111, 1'b1, 2'd2, 4'b0100, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd31, 4'b1111, 1'b1, 2'd2, 4'b0100, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd40, 4'b0101, 1'b1, 2'd1, 4'b0010, 1'b1};
        vecs[23] = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd40, 4'b1111, 1'b1, 2'd2, 4'b0100, 1'b0};
        vecs[24] = '{1'b1, 1'b1, 6'd41, 4'b0001, 1'b0, 6'd0,  4'b0000, 1'b0, 2'd2, 4'b0100, 1'b0};
        vecs[25] = '{1'b0, 1'b0, 6'd0,  4'b0000, 1'b1, 6'd41, 4'b1111, 1'b1, 2'd0, 4'b0001, 1'b0};

        rstn_i = 1'b1;
        idle_inputs();
        #2;
        rstn_i = 1'b0;
        #1;
        check_out(-1, 1'b0, 2'd0, 4'b0000, 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < N_VEC; i++) begin
            bus.flush_i     = vecs[i].flush;
            bus.hit_valid_i = vecs[i].hv;
            bus.hit_set_i   = vecs[i].hs;
            bus.hit_way_i   = vecs[i].hw;
            bus.fill_req_i  = vecs[i].fr;
            bus.fill_set_i  = vecs[i].fs;
            bus.way_valid_i = vecs[i].wv;
            @(posedge clk_i);
            #1;
            check_out(i, vecs[i].ev, vecs[i].ew, vecs[i].eoh, vecs[i].ei);
        end
        idle_inputs();
        @(posedge clk_i);
        #1;
        check_out(100, 1'b0, 2'd0, 4'b0001, 1'b0);

        // Reset asserted in the cycle after the request: pulse killed at once.
        bus.fill_req_i  = 1'b1;
        bus.fill_set_i  = 6'd12;
        bus.way_valid_i = 4'b1111;
        @(posedge clk_i);
        #1;
        idle_inputs();
        check_out(200, 1'b1, 2'd0, 4'b0001, 1'b0);
        rstn_i = 1'b0;
        #1;
        check_out(201, 1'b0, 2'd0, 4'b0000, 1'b0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (2) begin
            @(posedge clk_i);
            #1;
            check_out(202, 1'b0, 2'd0, 4'b0000, 1'b0);
        end

        // Reset asserted while the request is pending before its edge.
        bus.fill_req_i  = 1'b1;
        bus.fill_set_i  = 6'd12;
        bus.way_valid_i = 4'b1111;
        #2;
        rstn_i = 1'b0;
        @(posedge clk_i);
        #1;
        idle_inputs();
        check_out(300, 1'b0, 2'd0, 4'b0000, 1'b0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (2) begin
            @(posedge clk_i);
            #1;
            check_out(301, 1'b0, 2'd0, 4'b0000, 1'b0);
        end

        // Earlier vectors touched set 9; reset must have cleared it.
        do_reset();
        bus.fill_req_i  = 1'b1;
        bus.fill_set_i  = 6'd9;
        bus.way_valid_i = 4'b1111;
        @(posedge clk_i);
        #1;
        idle_inputs();
        check_out(400, 1'b1, 2'd0, 4'b0001, 1'b0);
        bus.fill_req_i  = 1'b1;
        bus.fill_set_i  = 6'd9;
        bus.way_valid_i = 4'b1111;
        @(posedge clk_i);
        #1;
        idle_inputs();
        check_out(401, 1'b1, 2'd2, 4'b0100, 1'b0);
        @(posedge clk_i);
        #1;
        check_out(402, 1'b0, 2'd2, 4'b0100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
